acc_bias_gen: RTL and testbench

//  Three-lane accumulator plus bias stage that produces the 21-bit acc+bias words consumed by the bound/ReLU stage.
//  - Sums a programmable number of signed partial sums (kernel taps) per lane onto a per-lane bias.
//  - Saturates the result to AB_BW bits.
//  - Presents the three results with a valid/ready handshake and a one-cycle bound-enable strobe.
//  - Sits between the PE array psum outputs and the bound/activation pipeline.

---
 rtl/acc_bias_gen_if.sv | 38 +++
 rtl/acc_bias_gen.sv | 123 ++++++++++++
 tb/tb_acc_bias_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_bias_gen_if.sv
// Handshake and data bundle for acc_bias_gen: bias load, start/length, psum stream and result.
// The unit connects through the slave modport; whoever drives it uses the master modport.
interface acc_bias_gen_if #(
  parameter int PSUM_BW = 16,
  parameter int BIAS_BW = 16,
  parameter int AB_BW   = 21,
  parameter int LEN_BW  = 5
);
  logic                      i_bias_we;
  logic signed [BIAS_BW-1:0] i_bias0;
  logic signed [BIAS_BW-1:0] i_bias1;
  logic signed [BIAS_BW-1:0] i_bias2;
  logic                      i_start;
  logic [LEN_BW-1:0]         i_acc_len;
  logic                      i_psum_valid;
  logic                      o_psum_ready;
  logic signed [PSUM_BW-1:0] i_psum0;
  logic signed [PSUM_BW-1:0] i_psum1;
  logic signed [PSUM_BW-1:0] i_psum2;
  logic signed [AB_BW-1:0]   o_acc_bias0;
  logic signed [AB_BW-1:0]   o_acc_bias1;
  logic signed [AB_BW-1:0]   o_acc_bias2;
  logic                      o_valid;
  logic                      i_ready;
  logic                      o_bound_en;

  modport slave (
    input  i_bias_we, i_bias0, i_bias1, i_bias2, i_start, i_acc_len,
    input  i_psum_valid, i_psum0, i_psum1, i_psum2, i_ready,
    output o_psum_ready, o_acc_bias0, o_acc_bias1, o_acc_bias2, o_valid, o_bound_en
  );

  modport master (
    output i_bias_we, i_bias0, i_bias1, i_bias2, i_start, i_acc_len,
    output i_psum_valid, i_psum0, i_psum1, i_psum2, i_ready,
    input  o_psum_ready, o_acc_bias0, o_acc_bias1, o_acc_bias2, o_valid, o_bound_en
  );
endinterface

// File: rtl/acc_bias_gen.sv
// Three-lane accumulator: seeds each lane with its bias, adds a programmable number of psum beats
// with per-beat saturation, then holds the result behind a valid/ready handshake.
module acc_bias_gen #(
  parameter int PSUM_BW = 16,
  parameter int BIAS_BW = 16,
  parameter int AB_BW   = 21,
  parameter int LEN_BW  = 5
) (
  input logic           clk,
  input logic           rst,
  acc_bias_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                  state;
  state_t                  next_state;
  logic signed [AB_BW-1:0] bias_q   [3];
  logic signed [AB_BW-1:0] acc_q    [3];
  logic signed [AB_BW-1:0] out_q    [3];
  logic signed [AB_BW-1:0] bias_in  [3];
  logic signed [AB_BW-1:0] sum      [3];
  logic signed [PSUM_BW-1:0] psum_in[3];
  logic [LEN_BW-1:0]       cnt_q;
  logic                    valid_q;
  logic                    bound_en_q;
  logic                    psum_ready;
  logic                    accept;
  logic                    start_ok;

  // Add one extra bit of headroom, then clamp if the sign and the bit below it disagree.
  function automatic logic signed [AB_BW-1:0] sat_add(
    input logic signed [AB_BW-1:0]   a,
    input logic signed [PSUM_BW-1:0] p
  );
    logic signed [AB_BW:0] s;
    s = (AB_BW+1)'(a) + (AB_BW+1)'(p);
    if (s[AB_BW] != s[AB_BW-1])
      sat_add = s[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}} : {1'b0, {(AB_BW-1){1'b1}}};
    else
      sat_add = s[AB_BW-1:0];
  endfunction

  always_comb begin
    bias_in[0] = AB_BW'(bus.i_bias0);
    bias_in[1] = AB_BW'(bus.i_bias1);
    bias_in[2] = AB_BW'(bus.i_bias2);
    psum_in[0] = bus.i_psum0;
    psum_in[1] = bus.i_psum1;
    psum_in[2] = bus.i_psum2;
    for (int l = 0; l < 3; l++) sum[l] = sat_add(acc_q[l], psum_in[l]);
  end

  assign start_ok = bus.i_start && (bus.i_acc_len != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    psum_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: if (start_ok) next_state = ACC;
      ACC: begin
        psum_ready = 1'b1;
        accept     = bus.i_psum_valid;
        if (accept && cnt_q == LEN_BW'(1)) next_state = HOLD;
      end
      HOLD:    if (bus.i_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A bias written in the same cycle as start is used directly as the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < 3; l++) begin
        bias_q[l] <= '0;
        acc_q[l]  <= '0;
        out_q[l]  <= '0;
      end
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      bound_en_q <= 1'b0;
    end else begin
      bound_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_bias_we)
            for (int l = 0; l < 3; l++) bias_q[l] <= bias_in[l];
          if (start_ok) begin
            for (int l = 0; l < 3; l++) acc_q[l] <= bus.i_bias_we ? bias_in[l] : bias_q[l];
            cnt_q <= bus.i_acc_len;
          end
        end
        ACC: begin
          if (accept) begin
            for (int l = 0; l < 3; l++) acc_q[l] <= sum[l];
            cnt_q <= cnt_q - LEN_BW'(1);
            if (cnt_q == LEN_BW'(1)) begin
              for (int l = 0; l < 3; l++) out_q[l] <= sum[l];
              valid_q    <= 1'b1;
              bound_en_q <= 1'b1;
            end
          end
        end
        HOLD: if (bus.i_ready) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.o_psum_ready = psum_ready;
  assign bus.o_acc_bias0  = out_q[0];
  assign bus.o_acc_bias1  = out_q[1];
  assign bus.o_acc_bias2  = out_q[2];
  assign bus.o_valid      = valid_q;
  assign bus.o_bound_en   = bound_en_q;

endmodule

// File: tb/tb_acc_bias_gen.sv
// Randomized bench for acc_bias_gen against a plain-integer model; a second, narrower instance
// shares the same stimulus so that saturation and re-entry are reachable.
module tb_acc_bias_gen;
  localparam int PSUM_BW = 16;
  localparam int BIAS_BW = 16;
  localparam int AB_BW   = 21;
  localparam int AB_BW_S = 17;
  localparam int LEN_BW  = 5;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   mBias[3];
  int   mAcc[3];
  int   mAccS[3];

  acc_bias_gen_if #(.PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW), .AB_BW(AB_BW),   .LEN_BW(LEN_BW)) ifa ();
  acc_bias_gen_if #(.PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW), .AB_BW(AB_BW_S), .LEN_BW(LEN_BW)) ifs ();

  assign ifs.i_bias_we    = ifa.i_bias_we;
  assign ifs.i_bias0      = ifa.i_bias0;
  assign ifs.i_bias1      = ifa.i_bias1;
  assign ifs.i_bias2      = ifa.i_bias2;
  assign ifs.i_start      = ifa.i_start;
  assign ifs.i_acc_len    = ifa.i_acc_len;
  assign ifs.i_psum_valid = ifa.i_psum_valid;
  assign ifs.i_psum0      = ifa.i_psum0;
  assign ifs.i_psum1      = ifa.i_psum1;
  assign ifs.i_psum2      = ifa.i_psum2;
  assign ifs.i_ready      = ifa.i_ready;

  acc_bias_gen #(.PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW), .AB_BW(AB_BW), .LEN_BW(LEN_BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  acc_bias_gen #(.PSUM_BW(PSUM_BW), .BIAS_BW(BIAS_BW), .AB_BW(AB_BW_S), .LEN_BW(LEN_BW)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampAdd(input int a, input int p, input int w);
    int s, mx, mn;
    s  = a + p;
    mx = (1 <<< (w - 1)) - 1;
    mn = -(1 <<< (w - 1));
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

  function automatic int outA(input int l);
    case (l)
      0:       return int'(ifa.o_acc_bias0);
      1:       return int'(ifa.o_acc_bias1);
      default: return int'(ifa.o_acc_bias2);
    endcase
  endfunction

  function automatic int outS(input int l);
    case (l)
      0:       return int'(ifs.o_acc_bias0);
      1:       return int'(ifs.o_acc_bias1);
      default: return int'(ifs.o_acc_bias2);
    endcase
  endfunction

  function automatic int genVal(input int mode);
    case (mode)
      0:       return int'($urandom_range(0, 65535)) - 32768;
      1:       return 32767;
      2:       return -32768;
      3:       return int'($urandom_range(0, 200)) - 100;
      4:       return 10;
      default: return 5;
    endcase
  endfunction

  task automatic checkResults(input string tag);
    for (int l = 0; l < 3; l++) begin
      checkOutput($sformatf("%s_w_lane%0d", tag, l), outA(l), mAcc[l]);
      checkOutput($sformatf("%s_n_lane%0d", tag, l), outS(l), mAccS[l]);
    end
  endtask

  task automatic driveBias(input int b0, input int b1, input int b2);
    ifa.i_bias0 = BIAS_BW'(b0);
    ifa.i_bias1 = BIAS_BW'(b1);
    ifa.i_bias2 = BIAS_BW'(b2);
  endtask

  task automatic loadBias(input int b0, input int b1, input int b2);
    @(negedge clk);
    ifa.i_bias_we = 1'b1;
    driveBias(b0, b1, b2);
    mBias[0] = b0; mBias[1] = b1; mBias[2] = b2;
    @(negedge clk);
    ifa.i_bias_we = 1'b0;
  endtask

  task automatic pokeIgnoredInputs();
    ifa.i_start   = 1'($urandom_range(0, 1));
    ifa.i_bias_we = 1'($urandom_range(0, 1));
    ifa.i_acc_len = LEN_BW'($urandom_range(0, 31));
    driveBias(genVal(0), genVal(0), genVal(0));
  endtask

  // Runs one tile: start, stream len beats with random gaps, then hold the result for holdCycles.
  task automatic applyStimulus(input int len, input int mode, input int gapPct,
                               input bit newBias, input bit poke, input int holdCycles);
    int accepted = 0;
    int cycles   = 0;
    int v[3];
    bit vld;
    @(negedge clk);
    ifa.i_start   = 1'b1;
    ifa.i_acc_len = LEN_BW'(len);
    if (newBias) begin
      for (int l = 0; l < 3; l++) mBias[l] = genVal(0);
      ifa.i_bias_we = 1'b1;
      driveBias(mBias[0], mBias[1], mBias[2]);
    end
    for (int l = 0; l < 3; l++) begin
      mAcc[l]  = mBias[l];
      mAccS[l] = mBias[l];
    end
    @(negedge clk);
    ifa.i_start   = 1'b0;
    ifa.i_bias_we = 1'b0;
    while (accepted < len && cycles < TIMEOUT) begin
      vld = ($urandom_range(0, 99) >= gapPct);
      for (int l = 0; l < 3; l++) v[l] = genVal(mode);
      ifa.i_psum_valid = vld;
      ifa.i_psum0 = PSUM_BW'(v[0]);
      ifa.i_psum1 = PSUM_BW'(v[1]);
      ifa.i_psum2 = PSUM_BW'(v[2]);
      if (poke) pokeIgnoredInputs();
      if (vld && ifa.o_psum_ready) begin
        for (int l = 0; l < 3; l++) begin
          mAcc[l]  = clampAdd(mAcc[l],  v[l], AB_BW);
          mAccS[l] = clampAdd(mAccS[l], v[l], AB_BW_S);
        end
        accepted++;
      end
      cycles++;
      @(negedge clk);
    end
    if (cycles >= TIMEOUT) checkOutput("accept_timeout", accepted, len);
    ifa.i_psum_valid = 1'b0;
    checkOutput("valid_rise", int'(ifa.o_valid), 1);
    checkOutput("bound_en_first", int'(ifa.o_bound_en), 1);
    checkOutput("psum_ready_hold", int'(ifa.o_psum_ready), 0);
    checkResults("result");
    for (int c = 1; c < holdCycles; c++) begin
      if (poke) pokeIgnoredInputs();
      @(negedge clk);
      checkOutput("valid_held", int'(ifa.o_valid), 1);
      checkOutput("bound_en_later", int'(ifa.o_bound_en), 0);
      checkOutput("psum_ready_held", int'(ifa.o_psum_ready), 0);
      checkResults("held");
    end
    ifa.i_ready   = 1'b1;
    ifa.i_start   = 1'b0;
    ifa.i_bias_we = 1'b0;
    @(negedge clk);
    ifa.i_ready = 1'b0;
    checkOutput("valid_drop", int'(ifa.o_valid), 0);
    checkOutput("bound_en_idle", int'(ifa.o_bound_en), 0);
    checkOutput("psum_ready_idle", int'(ifa.o_psum_ready), 0);
    checkResults("kept");
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, int'(ifa.o_valid), 0);
    checkOutput({tag, "_bound_en"}, int'(ifa.o_bound_en), 0);
    checkOutput({tag, "_psum_ready"}, int'(ifa.o_psum_ready), 0);
    for (int l = 0; l < 3; l++) begin
      checkOutput($sformatf("%s_w_lane%0d", tag, l), outA(l), 0);
      checkOutput($sformatf("%s_n_lane%0d", tag, l), outS(l), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.i_bias_we = 1'b0; ifa.i_start = 1'b0; ifa.i_acc_len = '0;
    ifa.i_psum_valid = 1'b0; ifa.i_ready = 1'b0;
    driveBias(0, 0, 0);
    ifa.i_psum0 = '0; ifa.i_psum1 = '0; ifa.i_psum2 = '0;
    for (int l = 0; l < 3; l++) mBias[l] = 0;
    @(negedge clk);
    @(negedge clk);
    checkZeroOutputs("reset");
    rst = 1'b0;

    loadBias(100, -50, 0);
    applyStimulus(3, 4, 0, 1'b0, 1'b0, 1);
    checkOutput("basic_lane0", outA(0), 130);
    checkOutput("basic_lane1", outA(1), -20);
    checkOutput("basic_lane2", outA(2), 30);

    applyStimulus(4, 3, 50, 1'b0, 1'b0, 1);
    applyStimulus(5, 0, 0, 1'b1, 1'b0, 5);

    loadBias(32767, 32767, 32767);
    applyStimulus(31, 1, 0, 1'b0, 1'b0, 1);
    loadBias(-32768, -32768, -32768);
    applyStimulus(31, 2, 0, 1'b0, 1'b0, 1);
    checkOutput("neg_full_lane0", outA(0), -1048576);
    checkOutput("neg_sat_narrow", outS(0), -65536);

    @(negedge clk);
    ifa.i_start   = 1'b1;
    ifa.i_acc_len = '0;
    @(negedge clk);
    ifa.i_start = 1'b0;
    checkOutput("len0_ignored", int'(ifa.o_psum_ready), 0);
    @(negedge clk);
    checkOutput("len0_still_idle", int'(ifa.o_psum_ready), 0);

    loadBias(genVal(0), genVal(0), genVal(0));
    applyStimulus(6, 0, 30, 1'b0, 1'b1, 3);
    applyStimulus(3, 3, 0, 1'b0, 1'b0, 1);

    @(negedge clk);
    ifa.i_start   = 1'b1;
    ifa.i_acc_len = LEN_BW'(4);
    @(negedge clk);
    ifa.i_start      = 1'b0;
    ifa.i_psum_valid = 1'b1;
    ifa.i_psum0 = 16'sd7; ifa.i_psum1 = 16'sd7; ifa.i_psum2 = 16'sd7;
    @(negedge clk);
    @(negedge clk);
    ifa.i_psum_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkZeroOutputs("midacc_reset");
    for (int l = 0; l < 3; l++) mBias[l] = 0;
    loadBias(0, 0, 0);
    applyStimulus(1, 5, 0, 1'b0, 1'b0, 1);
    checkOutput("after_reset_lane0", outA(0), 5);

    for (int t = 0; t < 20; t++) begin
      applyStimulus(int'($urandom_range(1, 31)), ($urandom_range(0, 1) == 0) ? 0 : 3,
                    int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
